fifo_to_lanes_distributor: RTL and testbench

Parametrised multi-lane successor of the single-lane FIFO-to-lane bridge. Pops LANES-byte words from the packet FIFO and spreads byte i of each word to lane i, with optional per-byte bit reversal. Runs one per-packet state machine that drives start/fin requests to every lane, including early finish for lanes that carry no byte in a partial last word. Sits between the DSI packet assembler FIFO and the LANES lane serializers. Adds explicit packet delimiting (fifo_last), a per-packet latched LP/HS mode and underrun detection.

---
 rtl/fifo_to_lanes_distributor.sv | 94 +++++++++
 tb/tb_fifo_to_lanes_distributor.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fifo_to_lanes_distributor.sv
// fifo_to_lanes_distributor: spreads FIFO words byte-per-lane with per-packet start/fin control
module fifo_to_lanes_distributor #(
  parameter int LANES       = 4,
  parameter int BIT_REVERSE = 1,
  parameter int CNT_W       = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*LANES-1:0] fifo_data,
  input  logic [CNT_W-1:0]   fifo_bytes,
  input  logic               fifo_last,
  input  logic               fifo_empty,
  output logic               fifo_read,
  input  logic               mode_lp_in,
  output logic [LANES-1:0]   lanes_mode_lp,
  output logic [LANES-1:0]   lanes_start_rqst,
  output logic [LANES-1:0]   lanes_fin_rqst,
  output logic [8*LANES-1:0] lanes_inp_data,
  input  logic [LANES-1:0]   lanes_data_rqst,
  output logic               busy,
  output logic               underrun_err,
  input  logic               err_clr
);
  typedef enum logic [1:0] {IDLE, START, ACTIVE, FINISH} state_t;
  state_t             state_q;
  logic [8*LANES-1:0] data_q;
  logic [LANES-1:0]   valid_q, started_q;
  logic               last_q, mode_q, err_q;
  logic [CNT_W-1:0]   nb;
  logic [LANES-1:0]   word_valid;
  logic [8*LANES-1:0] word_data;
  logic               pop_idle, pop_act, set_err, unused_rqst;
  assign unused_rqst = ^lanes_data_rqst;
  // Invalid lanes of a partial word get 0x00 so their serializer idles cleanly.
  always_comb begin
    nb = (fifo_bytes == '0 || fifo_bytes > CNT_W'(LANES)) ? CNT_W'(LANES) : fifo_bytes;
    word_valid = '0;
    word_data = '0;
    for (int i = 0; i < LANES; i++) begin
      word_valid[i] = !fifo_last || (CNT_W'(i) < nb);
      for (int j = 0; j < 8; j++)
        word_data[8*i+j] = word_valid[i] & ((BIT_REVERSE != 0) ? fifo_data[8*i+7-j] : fifo_data[8*i+j]);
    end
  end
  assign pop_idle = (state_q == IDLE) && !fifo_empty;
  assign pop_act  = (state_q == ACTIVE) && lanes_data_rqst[0] && !last_q && !fifo_empty;
  assign set_err  = (state_q == ACTIVE) && lanes_data_rqst[0] && !last_q && fifo_empty;
  assign fifo_read        = rst_n && (pop_idle || pop_act);
  assign lanes_start_rqst = (state_q == START) ? valid_q : '0;
  assign lanes_fin_rqst   = (state_q == FINISH) ? started_q : pop_act ? (started_q & ~word_valid) : '0;
  assign lanes_mode_lp    = {LANES{mode_q}};
  assign lanes_inp_data   = data_q;
  assign busy             = state_q != IDLE;
  assign underrun_err     = err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      valid_q   <= '0;
      started_q <= '0;
      last_q    <= 1'b0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= set_err ? 1'b1 : err_clr ? 1'b0 : err_q;
      case (state_q)
        IDLE: if (pop_idle) begin
          data_q  <= word_data;
          valid_q <= word_valid;
          last_q  <= fifo_last;
          mode_q  <= mode_lp_in;
          state_q <= START;
        end
        START: begin
          started_q <= valid_q;
          state_q   <= ACTIVE;
        end
        ACTIVE: if (lanes_data_rqst[0]) begin
          if (pop_act) begin
            data_q    <= word_data;
            valid_q   <= word_valid;
            last_q    <= fifo_last;
            started_q <= started_q & word_valid;
          end else state_q <= FINISH;
        end
        FINISH: begin
          started_q <= '0;
          mode_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_to_lanes_distributor.sv
// tb_fifo_to_lanes_distributor: directed checks of a 4-lane reversing and a 1-lane pass-through instance
module tb_fifo_to_lanes_distributor;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [31:0] fifo_data = 0, lanes_inp_data;
  logic [2:0]  fifo_bytes = 0;
  logic        fifo_last = 0, fifo_empty = 1, fifo_read, mode_lp_in = 0;
  logic [3:0]  lanes_mode_lp, lanes_start_rqst, lanes_fin_rqst, lanes_data_rqst = 4'hF;
  logic        busy, underrun_err, err_clr = 0;
  logic [7:0]  b_data = 0, b_out;
  logic [2:0]  b_bytes = 0;
  logic        b_last = 0, b_empty = 1, b_read, b_mode = 0, b_mode_o, b_start, b_fin, b_rqst = 1, b_busy, b_err;
  int checks = 0, errors = 0;
  fifo_to_lanes_distributor #(.LANES(4), .BIT_REVERSE(1), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_bytes(fifo_bytes), .fifo_last(fifo_last),
    .fifo_empty(fifo_empty), .fifo_read(fifo_read), .mode_lp_in(mode_lp_in), .lanes_mode_lp(lanes_mode_lp),
    .lanes_start_rqst(lanes_start_rqst), .lanes_fin_rqst(lanes_fin_rqst), .lanes_inp_data(lanes_inp_data),
    .lanes_data_rqst(lanes_data_rqst), .busy(busy), .underrun_err(underrun_err), .err_clr(err_clr));
  fifo_to_lanes_distributor #(.LANES(1), .BIT_REVERSE(0), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_data(b_data), .fifo_bytes(b_bytes), .fifo_last(b_last),
    .fifo_empty(b_empty), .fifo_read(b_read), .mode_lp_in(b_mode), .lanes_mode_lp(b_mode_o),
    .lanes_start_rqst(b_start), .lanes_fin_rqst(b_fin), .lanes_inp_data(b_out),
    .lanes_data_rqst(b_rqst), .busy(b_busy), .underrun_err(b_err), .err_clr(err_clr));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_busy", busy, 0); chk("rst_data", lanes_inp_data, 0); chk("rst_read", fifo_read, 0);
    chk("rst_mode", lanes_mode_lp, 0); chk("rst_err", underrun_err, 0);
    tick; rst_n = 1;
    // two full words
    fifo_data = 32'h01020304; fifo_empty = 0; #1;
    chk("t1_read_idle", fifo_read, 1);
    tick; fifo_data = 32'h80402010; fifo_last = 1; fifo_bytes = 4;
    chk("t1_start", lanes_start_rqst, 4'hF); chk("t1_read_start", fifo_read, 0);
    chk("t1_data0", lanes_inp_data, 32'h8040C020); chk("t1_busy", busy, 1);
    tick;
    chk("t1_start_gone", lanes_start_rqst, 0); chk("t1_read_act", fifo_read, 1); chk("t1_nofin", lanes_fin_rqst, 0);
    tick; fifo_empty = 1; #1;
    chk("t1_data1", lanes_inp_data, 32'h01020408); chk("t1_read_last", fifo_read, 0); chk("t1_nofin2", lanes_fin_rqst, 0);
    tick;
    chk("t1_fin", lanes_fin_rqst, 4'hF); chk("t1_busy_fin", busy, 1);
    tick;
    chk("t1_idle", busy, 0); chk("t1_fin_gone", lanes_fin_rqst, 0); chk("t1_err", underrun_err, 0);
    // partial last word
    fifo_data = 32'h01020304; fifo_last = 0; fifo_empty = 0; #1;
    chk("t2_read_idle", fifo_read, 1);
    tick; fifo_data = 32'h80402010; fifo_last = 1; fifo_bytes = 2;
    tick;
    chk("t2_read_act", fifo_read, 1); chk("t2_early_fin", lanes_fin_rqst, 4'hC);
    tick; fifo_empty = 1;
    chk("t2_data", lanes_inp_data, 32'h00000408); chk("t2_nofin", lanes_fin_rqst, 0);
    tick;
    chk("t2_fin", lanes_fin_rqst, 4'h3);
    tick;
    chk("t2_idle", busy, 0);
    // single one-byte LP packet
    fifo_data = 32'h000000AA; fifo_last = 1; fifo_bytes = 1; mode_lp_in = 1; fifo_empty = 0; #1;
    chk("t3_read", fifo_read, 1);
    tick; fifo_empty = 1; mode_lp_in = 0;
    chk("t3_start", lanes_start_rqst, 4'h1); chk("t3_mode", lanes_mode_lp, 4'hF);
    tick;
    chk("t3_data", lanes_inp_data, 32'h00000055); chk("t3_nofin", lanes_fin_rqst, 0); chk("t3_mode_act", lanes_mode_lp, 4'hF);
    tick;
    chk("t3_fin", lanes_fin_rqst, 4'h1); chk("t3_mode_fin", lanes_mode_lp, 4'hF);
    tick;
    chk("t3_mode_clr", lanes_mode_lp, 0); chk("t3_idle", busy, 0);
    // underrun with simultaneous clear
    fifo_data = 32'h11223344; fifo_last = 0; fifo_empty = 0;
    tick; fifo_empty = 1;
    tick; err_clr = 1; #1;
    chk("t4_read", fifo_read, 0); chk("t4_nofin", lanes_fin_rqst, 0);
    tick; err_clr = 0;
    chk("t4_err_set", underrun_err, 1); chk("t4_fin", lanes_fin_rqst, 4'hF);
    tick;
    chk("t4_idle", busy, 0); chk("t4_err_hold", underrun_err, 1);
    err_clr = 1;
    tick; err_clr = 0;
    chk("t4_err_clr", underrun_err, 0);
    // async reset mid-packet
    lanes_data_rqst = 0; fifo_data = 32'h01020304; fifo_empty = 0;
    tick; tick;
    chk("t5_active", busy, 1); chk("t5_data", lanes_inp_data, 32'h8040C020);
    rst_n = 0; #1;
    chk("t5_busy", busy, 0); chk("t5_data0", lanes_inp_data, 0); chk("t5_read", fifo_read, 0);
    chk("t5_fin", lanes_fin_rqst, 0); chk("t5_start", lanes_start_rqst, 0);
    tick;
    chk("t5_fin_hold", lanes_fin_rqst, 0);
    rst_n = 1; lanes_data_rqst = 4'hF; fifo_last = 1; fifo_bytes = 0; #1;
    chk("t5_read_again", fifo_read, 1);
    tick; fifo_empty = 1;
    chk("t5_start_again", lanes_start_rqst, 4'hF);
    tick; tick;
    chk("t5_fin_again", lanes_fin_rqst, 4'hF);
    tick;
    // 1-lane pass-through, mode toggles ignored
    b_data = 8'hA5; b_mode = 1; b_empty = 0; #1;
    chk("t6_read", b_read, 1);
    tick; b_data = 8'h3C; b_last = 1; b_bytes = 1; b_mode = 0;
    chk("t6_start", b_start, 1); chk("t6_data0", b_out, 8'hA5); chk("t6_mode", b_mode_o, 1);
    tick;
    chk("t6_read_act", b_read, 1); chk("t6_nofin", b_fin, 0);
    tick; b_empty = 1; b_mode = 1;
    chk("t6_data1", b_out, 8'h3C); chk("t6_mode_hold", b_mode_o, 1);
    tick;
    chk("t6_fin", b_fin, 1);
    tick;
    chk("t6_idle", b_busy, 0); chk("t6_mode_clr", b_mode_o, 0); chk("t6_err", b_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
